mem_wb_skid_reg: RTL and testbench

Parametrised MEM/WB pipeline register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a saturating stall counter. It sits between the memory stage and the write-back stage and carries the datapath lanes, the instruction word and the write-back control bits. Unlike a plain enable-less register, it holds data under back-pressure without dropping or duplicating it. It also turns flushed or empty slots into control-zero bubbles, so no register write occurs.

---
 rtl/mem_wb_skid_reg.sv | 127 ++++++++++++
 tb/tb_mem_wb_skid_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with a 2-entry skid buffer, a synchronous flush and a saturating stall counter.
// Latency is one edge from accept to output; in_ready is registered and drops only while the skid entry is occupied.
module mem_wb_skid_reg #(
   parameter int DATA_W  = 8,
   parameter int LANES   = 3,
   parameter int INSTR_W = 19,
   parameter int CTRL_W  = 3,
   parameter int CNT_W   = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   in_data,
   input  logic [INSTR_W-1:0]        in_instr,
   input  logic [CTRL_W-1:0]         in_ctrl,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_W-1:0]   out_data,
   output logic [INSTR_W-1:0]        out_instr,
   output logic [CTRL_W-1:0]         out_ctrl,
   output logic [CNT_W-1:0]          stall_cnt
);

   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic                      ready_q;
   logic                      acc;
   logic                      con;
   logic [LANES*DATA_W-1:0]   main_data;
   logic [LANES*DATA_W-1:0]   skid_data;
   logic [INSTR_W-1:0]        main_instr;
   logic [INSTR_W-1:0]        skid_instr;
   logic [CTRL_W-1:0]         main_ctrl;
   logic [CTRL_W-1:0]         skid_ctrl;

   assign acc = in_valid & in_ready;
   assign con = out_valid & out_ready;

   // in_ready is the registered image of "next state is not SKID".
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt != SKID);
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (acc) state_nxt = FULL;
            FULL: begin
               if (acc && !con)      state_nxt = SKID;
               else if (!acc && con) state_nxt = EMPTY;
            end
            SKID:  if (con) state_nxt = FULL;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_comb begin
      in_ready  = ready_q;
      out_valid = (state != EMPTY);
      out_data  = main_data;
      out_instr = main_instr;
      out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
   end

   // Payload moves follow the same transitions; a flush leaves stale payload behind its cleared state.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_data  <= '0;
         main_instr <= '0;
         main_ctrl  <= '0;
         skid_data  <= '0;
         skid_instr <= '0;
         skid_ctrl  <= '0;
      end else if (!flush) begin
         case (state)
            EMPTY: begin
               if (acc) begin
                  main_data  <= in_data;
                  main_instr <= in_instr;
                  main_ctrl  <= in_ctrl;
               end
            end
            FULL: begin
               if (acc && con) begin
                  main_data  <= in_data;
                  main_instr <= in_instr;
                  main_ctrl  <= in_ctrl;
               end else if (acc) begin
                  skid_data  <= in_data;
                  skid_instr <= in_instr;
                  skid_ctrl  <= in_ctrl;
               end
            end
            SKID: begin
               if (con) begin
                  main_data  <= skid_data;
                  main_instr <= skid_instr;
                  main_ctrl  <= skid_ctrl;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg: reset, streaming, skid, flush, bubble masking and counter saturation.
module tb_mem_wb_skid_reg;

   localparam int DATA_W  = 8;
   localparam int LANES   = 3;
   localparam int INSTR_W = 19;
   localparam int CTRL_W  = 3;
   localparam int CNT_W   = 4;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] in_data = '0;
   logic [INSTR_W-1:0]      in_instr = '0;
   logic [CTRL_W-1:0]       in_ctrl = '0;
   logic                    flush = 1'b0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [LANES*DATA_W-1:0] out_data;
   logic [INSTR_W-1:0]      out_instr;
   logic [CTRL_W-1:0]       out_ctrl;
   logic [CNT_W-1:0]        stall_cnt;

   int checks = 0;
   int failures = 0;

   mem_wb_skid_reg #(.DATA_W(DATA_W), .LANES(LANES), .INSTR_W(INSTR_W),
                     .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_instr(in_instr), .in_ctrl(in_ctrl), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_instr(out_instr), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [23:0] d, input logic [18:0] i, input logic [2:0] c);
      in_valid = v;
      in_data  = d;
      in_instr = i;
      in_ctrl  = c;
   endtask

   localparam logic [23:0] DA = 24'h332211, DB = 24'h665544, DC = 24'h998877;
   localparam logic [18:0] IA = 19'h12345,  IB = 19'h23456,  IC = 19'h34567;
   localparam logic [23:0] DD = 24'hA1A2A3, DE = 24'hB1B2B3, DF = 24'hC1C2C3;
   localparam logic [18:0] ID = 19'h0_1111, IE = 19'h0_2222, IF = 19'h0_3333;

   initial begin
      // Reset held with random traffic
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 24'($urandom), 19'($urandom), 3'($urandom));
         out_ready = 1'($urandom);
         step();
      end
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_ctrl",  32'(out_ctrl),  32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_instr", 32'(out_instr), 32'd0);

      // Streaming with out_ready=1
      reset = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, DA, IA, 3'b011);
      step();
      chk("str_a_valid", 32'(out_valid), 32'd1);
      chk("str_a_data",  32'(out_data),  32'(DA));
      chk("str_a_instr", 32'(out_instr), 32'(IA));
      chk("str_a_ctrl",  32'(out_ctrl),  32'd3);
      drive(1'b1, DB, IB, 3'b011);
      step();
      chk("str_b_data",  32'(out_data),  32'(DB));
      chk("str_b_instr", 32'(out_instr), 32'(IB));
      drive(1'b1, DC, IC, 3'b011);
      step();
      chk("str_c_data",  32'(out_data),  32'(DC));
      chk("str_c_instr", 32'(out_instr), 32'(IC));
      chk("str_in_ready", 32'(in_ready), 32'd1);

      // Bubble masking: held entry drained, in_ctrl=111 but not valid
      drive(1'b0, 24'hFFFFFF, 19'h7FFFF, 3'b111);
      step();
      chk("bub_valid", 32'(out_valid), 32'd0);
      chk("bub_ctrl",  32'(out_ctrl),  32'd0);
      chk("bub_data_unmasked", 32'(out_data), 32'(DC));
      step();
      chk("bub_ctrl2", 32'(out_ctrl), 32'd0);
      chk("str_stall_cnt", 32'(stall_cnt), 32'd0);

      // Skid under back-pressure
      out_ready = 1'b0;
      drive(1'b1, DA, IA, 3'b001);
      step();
      chk("skid_a_data", 32'(out_data), 32'(DA));
      chk("skid_rdy1",   32'(in_ready), 32'd1);
      chk("skid_stall0", 32'(stall_cnt), 32'd0);
      drive(1'b1, DB, IB, 3'b010);
      step();
      chk("skid_rdy_fall", 32'(in_ready), 32'd0);
      chk("skid_hold_a",   32'(out_data), 32'(DA));
      chk("skid_stall1",   32'(stall_cnt), 32'd1);
      drive(1'b1, DC, IC, 3'b011);
      step();
      chk("skid_rdy_low", 32'(in_ready), 32'd0);
      chk("skid_stall2",  32'(stall_cnt), 32'd2);
      step();
      chk("skid_stall3",  32'(stall_cnt), 32'd3);
      chk("skid_hold_a2", 32'(out_data), 32'(DA));
      chk("skid_ctrl_a",  32'(out_ctrl), 32'd1);
      out_ready = 1'b1;
      step();
      chk("skid_out_b",      32'(out_data),  32'(DB));
      chk("skid_out_b_ctrl", 32'(out_ctrl),  32'd2);
      chk("skid_rdy_rise",   32'(in_ready),  32'd1);
      chk("skid_stall_hold", 32'(stall_cnt), 32'd3);
      step();
      chk("skid_out_c",       32'(out_data),  32'(DC));
      chk("skid_out_c_instr", 32'(out_instr), 32'(IC));
      drive(1'b0, '0, '0, '0);
      step();
      chk("skid_drained", 32'(out_valid), 32'd0);

      // Flush while in SKID, with a same-cycle input
      out_ready = 1'b0;
      drive(1'b1, DD, ID, 3'b001);
      step();
      drive(1'b1, DE, IE, 3'b001);
      step();
      chk("fl_pre_rdy", 32'(in_ready), 32'd0);
      flush = 1'b1;
      drive(1'b1, DF, IF, 3'b111);
      step();
      flush = 1'b0;
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_ctrl",  32'(out_ctrl),  32'd0);
      chk("fl_rdy",   32'(in_ready),  32'd1);
      drive(1'b0, '0, '0, '0);
      out_ready = 1'b1;
      step();
      chk("fl_no_deliver", 32'(out_valid), 32'd0);
      step();
      chk("fl_no_deliver2", 32'(out_valid), 32'd0);

      // Flush together with consume while FULL
      drive(1'b1, DD, ID, 3'b001);
      step();
      flush = 1'b1;
      drive(1'b1, DE, IE, 3'b001);
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0, '0);
      chk("flcon_valid", 32'(out_valid), 32'd0);
      chk("flcon_rdy",   32'(in_ready),  32'd1);

      // Stall counter saturation
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("sat_start", 32'(stall_cnt), 32'd0);
      out_ready = 1'b0;
      drive(1'b1, DA, IA, 3'b001);
      step();
      drive(1'b0, '0, '0, '0);
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 10) chk("sat_mid", 32'(stall_cnt), 32'd10);
         if (k == 15) chk("sat_at15", 32'(stall_cnt), 32'd15);
      end
      chk("sat_hold", 32'(stall_cnt), 32'd15);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("sat_flush_valid", 32'(out_valid), 32'd0);
      chk("sat_after_flush", 32'(stall_cnt), 32'd15);
      step();
      chk("sat_after_flush2", 32'(stall_cnt), 32'd15);

      // Reset mid-operation discards entries
      drive(1'b1, DB, IB, 3'b011);
      step();
      chk("mid_loaded", 32'(out_data), 32'(DB));
      reset = 1'b1;
      flush = 1'b1;
      step();
      reset = 1'b0;
      flush = 1'b0;
      drive(1'b0, '0, '0, '0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data",  32'(out_data),  32'd0);
      chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
      chk("mid_rst_rdy",   32'(in_ready),  32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
